// File: rtl/snn_axil_pkg.sv
// rtl/snn_axil_pkg.sv - shared state, response and register-map definitions for the AXI4-Lite config master
package snn_axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_CONFIG    = 8'h04;
  localparam logic [7:0] REG_LEAK      = 8'h08;
  localparam logic [7:0] REG_THRESH    = 8'h0C;
  localparam logic [7:0] REG_REFRAC    = 8'h10;
  localparam logic [7:0] REG_STATUS    = 8'h14;
  localparam logic [7:0] REG_SPIKE_CNT = 8'h18;

  localparam logic [15:0] LAT_MAX = 16'hFFFF;

  function automatic logic [15:0] lat_inc(input logic [15:0] v);
    return (v == LAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/snn_axil_cfg_master.sv
// rtl/snn_axil_cfg_master.sv - single-outstanding AXI4-Lite master driven by a cmd/rsp port
module snn_axil_cfg_master
  import snn_axil_pkg::*;
#(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 8
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [15:0]                       rsp_latency,
  output logic                              busy,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};

  state_t            r_state;
  state_t            w_state_nx;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW/8-1:0]   r_wstrb;
  logic              r_awvalid, r_wvalid, r_aw_done, r_w_done, r_bready;
  logic              r_arvalid, r_rready;
  logic              r_rsp_valid;
  logic [DW-1:0]     r_rsp_rdata;
  logic [1:0]        r_rsp_resp;
  logic [15:0]       r_lat, r_rsp_lat;

  logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_done_nx, w_w_done_nx, w_cnt_en;

  assign w_accept     = (r_state == S_IDLE) && cmd_valid;
  assign w_aw_hs      = r_awvalid && m00_axi_awready;
  assign w_w_hs       = r_wvalid && m00_axi_wready;
  assign w_aw_done_nx = r_aw_done || w_aw_hs;
  assign w_w_done_nx  = r_w_done || w_w_hs;
  assign w_b_hs       = (r_state == S_WRESP) && r_bready && m00_axi_bvalid;
  assign w_ar_hs      = r_arvalid && m00_axi_arready;
  assign w_r_hs       = (r_state == S_RDATA) && r_rready && m00_axi_rvalid;
  assign w_cnt_en     = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                        (r_state == S_READ)  || (r_state == S_RDATA);

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) r_state <= S_IDLE;
    else                r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_nx = cmd_write ? S_WRITE : S_READ;
      S_WRITE: if (w_aw_done_nx && w_w_done_nx) w_state_nx = S_WRESP;
      S_WRESP: if (w_b_hs) w_state_nx = S_RESP;
      S_READ:  if (w_ar_hs) w_state_nx = S_RDATA;
      S_RDATA: if (w_r_hs) w_state_nx = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    if (r_state == S_IDLE) begin
      cmd_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // Capture registers, per-channel valids and the response latch.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXI_OKAY;
      r_lat       <= '0;
      r_rsp_lat   <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= cmd_addr & ADDR_MASK;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
        r_arvalid <= !cmd_write;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_lat     <= '0;
      end
      if (w_cnt_en) r_lat <= lat_inc(r_lat);
      if (r_state == S_WRITE) begin
        if (w_aw_hs) begin
          r_awvalid <= 1'b0;
          r_aw_done <= 1'b1;
        end
        if (w_w_hs) begin
          r_wvalid <= 1'b0;
          r_w_done <= 1'b1;
        end
        if (w_aw_done_nx && w_w_done_nx) r_bready <= 1'b1;
      end
      if (w_b_hs) begin
        r_bready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m00_axi_bresp;
        r_rsp_lat   <= lat_inc(r_lat);
      end
      if ((r_state == S_READ) && w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_r_hs) begin
        r_rready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= m00_axi_rdata;
        r_rsp_resp  <= m00_axi_rresp;
        r_rsp_lat   <= lat_inc(r_lat);
      end
      if ((r_state == S_RESP) && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  assign m00_axi_awaddr  = r_addr;
  assign m00_axi_araddr  = r_addr;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = r_wstrb;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = r_bready;
  assign m00_axi_arvalid = r_arvalid;
  assign m00_axi_rready  = r_rready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_rdata       = r_rsp_rdata;
  assign rsp_resp        = r_rsp_resp;
  assign rsp_latency     = r_rsp_lat;

endmodule

// File: tb/tb_snn_axil_cfg_master.sv
// tb/tb_snn_axil_cfg_master.sv - vector table plus scoreboard bench for snn_axil_cfg_master
module tb_snn_axil_cfg_master;
  import snn_axil_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [15:0] lat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd, wd, bd, ard, rd;
    logic [1:0]  bresp, rresp;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  snn_axil_cfg_master #(.C_M00_AXI_DATA_WIDTH(32), .C_M00_AXI_ADDR_WIDTH(8)) dut (
    .m00_axi_aclk(clk), .m00_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_latency(rsp_latency), .busy(busy),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  // Slave model: ready after N cycles of valid; B/R response N cycles after the address/data handshake.
  int          awd, wd, bd, ard, rd;
  logic [1:0]  bresp_v, rresp_v;
  logic [31:0] regs [0:7];
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          n_aw, n_w, n_b, n_ar, n_r;
  logic        aw_got, w_got, r_pend;
  logic [7:0]  aw_a, ar_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;

  assign awready = awvalid && (aw_cnt >= awd);
  assign wready  = wvalid && (w_cnt >= wd);
  assign bvalid  = aw_got && w_got && (b_cnt >= bd - 1);
  assign bresp   = bvalid ? bresp_v : 2'b00;
  assign arready = arvalid && (ar_cnt >= ard);
  assign rvalid  = r_pend && (r_cnt >= rd - 1);
  assign rdata   = rvalid ? regs[ar_a[4:2]] : 32'h0;
  assign rresp   = rvalid ? rresp_v : 2'b00;

  always @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < 8; i++) regs[i] <= (i == 5) ? 32'h0000_00A5 : 32'h0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; n_aw <= n_aw + 1; end
      if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; n_w <= n_w + 1; end
      if (aw_got && w_got) begin
        if (bvalid && bready) begin
          aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; n_b <= n_b + 1;
          for (int i = 0; i < 4; i++)
            if (w_s[i]) regs[aw_a[4:2]][8*i +: 8] <= w_d[8*i +: 8];
        end else b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready) begin r_pend <= 1'b1; ar_a <= araddr; n_ar <= n_ar + 1; end
      if (r_pend) begin
        if (rvalid && rready) begin r_pend <= 1'b0; r_cnt <= 0; n_r <= n_r + 1; end
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t vecs[10];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] d, input logic [1:0] r, input logic [15:0] l);
    exp_t e;
    e.rdata = d; e.resp = r; e.lat = l;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input int awd_i, input int wd_i, input int bd_i,
                                  input int ard_i, input int rd_i, input logic [1:0] br,
                                  input logic [1:0] rr, input exp_t e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.wstrb = s;
    v.awd = awd_i; v.wd = wd_i; v.bd = bd_i; v.ard = ard_i; v.rd = rd_i;
    v.bresp = br; v.rresp = rr; v.e = e;
    return v;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!areset) begin
        if (awvalid && awready) chk("awaddr_align", {30'd0, awaddr[1:0]}, 32'd0);
        if (arvalid && arready) chk("araddr_align", {30'd0, araddr[1:0]}, 32'd0);
        if (rsp_valid && rsp_ready) begin
          chk("sb_nonempty", (sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("rsp_latency", rsp_latency, e.lat);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input exp_t e);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_before_issue", cmd_ready, 32'd1);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    sb_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    chk("rsp_valid_timeout", rsp_valid, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int aw0, w0, b0, ar0, r0;
    awd = v.awd; wd = v.wd; bd = v.bd; ard = v.ard; rd = v.rd;
    bresp_v = v.bresp; rresp_v = v.rresp; rsp_ready = 1'b1;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    issue(v.wr, v.addr, v.wdata, v.wstrb, v.e);
    wait_rsp();
    tick();
    chk($sformatf("v%0d_handshakes", idx),
        {12'd0, 4'(n_aw - aw0), 4'(n_w - w0), 4'(n_b - b0), 4'(n_ar - ar0), 4'(n_r - r0)},
        v.wr ? 32'h0001_1100 : 32'h0000_0011);
    chk($sformatf("v%0d_idle_after", idx), {busy, cmd_ready}, 32'b01);
  endtask

  initial begin
    int aw0, w0, b0, ar0, r0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    awd = 0; wd = 0; bd = 1; ard = 0; rd = 1; bresp_v = AXI_OKAY; rresp_v = AXI_OKAY;
    areset = 1'b1;
    repeat (3) tick();

    chk("reset_status", {cmd_ready, busy, rsp_valid}, 32'b100);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_resp_lat", {rsp_resp, rsp_latency}, 32'h0);
    chk("reset_axi_handshake", {awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("reset_axi_addr_prot", {awaddr, araddr, awprot, arprot}, 32'h0);
    chk("reset_axi_wdata_wstrb", {wdata[27:0], wstrb} | {28'h0, wstrb} | {4'h0, wdata[31:28], 24'h0}, 32'h0);
    areset = 1'b0;
    tick();

    vecs[0] = mk_vec(1, REG_CONFIG, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'h0, AXI_OKAY, 16'd2));
    vecs[1] = mk_vec(0, REG_CONFIG, 32'h0, 4'h0, 0, 0, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'hDEADBEEF, AXI_OKAY, 16'd2));
    vecs[2] = mk_vec(1, REG_CTRL, 32'h0000_0001, 4'hF, 2, 2, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'h0, AXI_OKAY, 16'd4));
    vecs[3] = mk_vec(0, REG_STATUS, 32'h0, 4'h0, 0, 0, 1, 2, 3, AXI_OKAY, AXI_OKAY, mk_exp(32'h0000_00A5, AXI_OKAY, 16'd6));
    vecs[4] = mk_vec(1, REG_THRESH, 32'h0000_FFFF, 4'b0011, 3, 0, 2, 0, 1, AXI_SLVERR, AXI_OKAY, mk_exp(32'h0, AXI_SLVERR, 16'd6));
    vecs[5] = mk_vec(0, REG_THRESH, 32'h0, 4'h0, 0, 0, 1, 0, 1, AXI_OKAY, AXI_DECERR, mk_exp(32'h0000_FFFF, AXI_DECERR, 16'd2));
    vecs[6] = mk_vec(0, 8'h07, 32'h0, 4'h0, 0, 0, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'hDEADBEEF, AXI_OKAY, 16'd2));
    vecs[7] = mk_vec(1, 8'h13, 32'hAABBCCDD, 4'b1000, 0, 1, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'h0, AXI_OKAY, 16'd3));
    vecs[8] = mk_vec(0, REG_REFRAC, 32'h0, 4'h0, 0, 0, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'hAA00_0000, AXI_OKAY, 16'd2));
    vecs[9] = mk_vec(0, REG_SPIKE_CNT, 32'h0, 4'h0, 0, 0, 1, 1, 2, AXI_OKAY, AXI_OKAY, mk_exp(32'h0, AXI_OKAY, 16'd4));
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Skewed write: AW completes at once, W five cycles later.
    awd = 0; wd = 5; bd = 1; bresp_v = AXI_OKAY; rsp_ready = 1'b1; b0 = n_b;
    issue(1, REG_LEAK, 32'h1234_5678, 4'hF, mk_exp(32'h0, AXI_OKAY, 16'd7));
    chk("skew_c1_valids", {awvalid, wvalid}, 32'b11);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("skew_w_held", {awvalid, wvalid, bready}, 32'b010);
      chk("skew_wdata_stable", wdata, 32'h1234_5678);
    end
    tick();
    chk("skew_bready", {wvalid, bready}, 32'b01);
    wait_rsp();
    tick();
    chk("skew_single_b", n_b - b0, 32'd1);

    // Response backpressure with a stray command held upstream.
    ard = 0; rd = 1; rresp_v = AXI_OKAY; rsp_ready = 1'b0;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    issue(0, REG_STATUS, 32'h0, 4'h0, mk_exp(32'h0000_00A5, AXI_OKAY, 16'd2));
    wait_rsp();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_SPIKE_CNT; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold", {rsp_valid, cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready}, 32'b1010_0000);
      chk("bp_rdata_stable", rsp_rdata, 32'h0000_00A5);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", {busy, cmd_ready, rsp_valid}, 32'b010);
    chk("bp_handshakes", {12'd0, 4'(n_aw - aw0), 4'(n_w - w0), 4'(n_b - b0), 4'(n_ar - ar0), 4'(n_r - r0)}, 32'h0000_0011);

    // Reset while arvalid is waiting for arready.
    ard = 20; rd = 1;
    issue(0, REG_CTRL, 32'h0, 4'h0, mk_exp(32'h0, AXI_OKAY, 16'd0));
    tick();
    chk("rst_arvalid_before", arvalid, 32'd1);
    areset = 1'b1;
    tick();
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("rst_status", {cmd_ready, busy, rsp_valid}, 32'b100);
    chk("rst_latency", rsp_latency, 32'h0);
    areset = 1'b0;
    sb_q.delete();
    tick();
    run_vec(100, mk_vec(1, REG_REFRAC, 32'h0000_0042, 4'hF, 0, 0, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'h0, AXI_OKAY, 16'd2)));
    run_vec(101, mk_vec(0, REG_REFRAC, 32'h0, 4'h0, 0, 0, 1, 0, 1, AXI_OKAY, AXI_OKAY, mk_exp(32'h0000_0042, AXI_OKAY, 16'd2)));

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snn_axil_cfg_master.md
# snn_axil_cfg_master

AXI4-Lite master that turns a simple single-command request/response port into AXI4-Lite read and write transactions. It sits between the on-chip configuration sequencer (bootstrap/test controller) and the accelerator's AXI-Lite register slave. It programs ctrl/config/leak/threshold/refractory registers and polls status and spike count without a processor. It handles one transaction at a time, measures per-transaction latency, and reports the slave response code.

## Interface
Parameters:
- C_M00_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_M00_AXI_ADDR_WIDTH, 8: address width.

Ports:
- m00_axi_aclk  in  1  single clock for all logic.
- m00_axi_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address; bits [1:0] are forced to 0 on AXI.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP copied from the slave.
- rsp_latency  out  16  cycles from command accept to B/R handshake, saturating.
- busy  out  1  high whenever the state is not IDLE.
- m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master signals.
- awprot and arprot are tied to 3'b000.

## Operation
State machine: IDLE, WRITE, WRESP, READ, RDATA, RESP.

- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, capture addr/wdata/wstrb/write into registers.
  - Go to WRITE or READ.
- **WRITE**
  - awvalid and wvalid are asserted together.
  - Each valid drops independently on its own handshake; a per-channel "done" flag tracks completion.
  - When both are done (same or different cycles), go to WRESP with bready = 1.
- **WRESP**
  - On bvalid & bready: capture bresp, set rsp_rdata = 0, go to RESP.
- **READ**
  - arvalid = 1 until arready, then go to RDATA with rready = 1.
- **RDATA**
  - On rvalid & rready: capture rdata and rresp, go to RESP.
- **RESP**
  - rsp_valid = 1.
  - When rsp_ready = 1, go to IDLE.
  - The captured response stays stable while rsp_valid = 1 and rsp_ready = 0.

Latency counter:
- Cleared to 0 on command accept.
- Increments once per cycle in WRITE, WRESP, READ and RDATA.
- Saturates at 16'hFFFF.
- Frozen in RESP and copied to rsp_latency there.

Protocol and boundary rules:
- AXI address, data and strobe outputs come from the capture registers and are stable while their valid is high.
- No valid is withdrawn before its handshake, and there is no timeout or abort.
- awready and wready in the same cycle: both done, go to WRESP next cycle.
- The slave may assert ready before valid; only ready & valid counts as a handshake.
- bvalid or rvalid outside the wait states is ignored (protocol error by the slave; not handled).
- cmd_valid while not in IDLE: ignored; the command is held upstream.
- Reset mid-transaction: all state returns to IDLE and all valids deassert the next cycle. The slave is assumed to be reset by the same reset.
- SLVERR/DECERR are not interpreted; they are passed through on rsp_resp.

## Timing
- Reset values:
  - cmd_ready = 1; busy = 0; rsp_valid = 0.
  - rsp_rdata = 0; rsp_resp = 0; rsp_latency = 0.
  - All AXI valid and ready outputs = 0; AXI address/data/strb = 0.
- All outputs are registered except cmd_ready and busy, which decode the state register.
- With zero-wait handshakes:
  - Accept at cycle 0; awvalid/wvalid (or arvalid) high at cycle 1.
  - Handshake at cycle 1, bready/rready high at cycle 2, B/R handshake at cycle 2.
  - rsp_valid at cycle 3, rsp_latency = 2.
- Back-to-back commands: the next command can be accepted the cycle after the RESP handshake. Minimum period is 4 cycles per transaction.

## Structure
- Shared package snn_axil_pkg holds:
  - The state enum.
  - AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - The register offset constants (CTRL 0x00, CONFIG 0x04, LEAK 0x08, THRESH 0x0C, REFRAC 0x10, STATUS 0x14, SPIKE_CNT 0x18).
- No sub-module; a single FSM plus capture registers. The saturating counter stays inline.

## Test plan
- **Write, zero-wait slave:** write 0x04 = 0xDEADBEEF, wstrb 4'hF. Expect one AW and one W handshake, then rsp_resp = 0, rsp_latency = 2, and the slave config_reg reads back 0xDEADBEEF.
- **Skewed write channels:** wready delayed 5 cycles after awready. Expect awvalid to drop after its handshake, wvalid held with stable data, then a single B, and rsp_latency = 7.
- **Read with wait states:** status input 0x0000_00A5, arready delayed 2 cycles, rvalid delayed 3 cycles. Expect rsp_rdata = 0xA5 and rsp_latency = 6.
- **Response backpressure:** rsp_ready low for 10 cycles. Expect rsp_valid and rsp_rdata stable, cmd_ready = 0, and no AXI activity.
- **Error passthrough:** slave returns bresp = 2'b10. Expect rsp_resp = 2'b10 and the FSM back in IDLE after rsp_ready.
- **Reset mid-read:** assert m00_axi_areset while arvalid = 1. Expect all valids = 0, cmd_ready = 1, rsp_valid = 0 the next cycle, and a following write completing normally.
